// File: rtl/mod_mul_host_if.sv
// Word-serial host front end for the interleaved modular multiplier: streams in a/b/m,
// pulses the multiplier start, waits for done, streams out y. Optional feature macro: MM_HOST_TIMEOUT_EN.
module mod_mul_host_if #(
   parameter int NBITS   = 4096,
   parameter int PBITS   = 16,
   parameter int NBYP    = 256,
   parameter int TIMEOUT = 8192
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PBITS-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PBITS-1:0] out_data,
   output logic             busy,
   output logic             err_p,
   output logic             mm_enable_p,
   output logic [NBITS-1:0] mm_a,
   output logic [NBITS-1:0] mm_b,
   output logic [NBITS-1:0] mm_m,
   input  logic [NBITS-1:0] mm_y,
   input  logic             mm_done_irq_p,
   output logic [1:0]       dbg_state
);

   // Handshake rule on both ports: a word moves on a rising edge where valid & ready are
   // both high; the producer holds valid and data stable until that edge.

   typedef enum logic [1:0] {
      S_LOAD   = 2'd0,
      S_START  = 2'd1,
      S_WAIT   = 2'd2,
      S_UNLOAD = 2'd3
   } state_t;

   localparam int WCW = (3 * NBYP > 1) ? $clog2(3 * NBYP) : 1;

   state_t           state, state_nxt;
   logic [WCW-1:0]   wc;
   logic [NBITS-1:0] a_q, b_q, m_q, y_q;
   logic             in_fire, out_fire, last_in, last_out, tmo;

   assign in_ready    = (state == S_LOAD) && !rst;
   assign out_valid   = (state == S_UNLOAD);
   assign out_data    = y_q[PBITS-1:0];
   assign busy        = (state == S_START) || (state == S_WAIT);
   assign mm_enable_p = (state == S_START);
   assign mm_a        = a_q;
   assign mm_b        = b_q;
   assign mm_m        = m_q;
   assign dbg_state   = state;

   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;
   assign last_in  = (wc == WCW'(3 * NBYP - 1));
   assign last_out = (wc == WCW'(NBYP - 1));

`ifdef MM_HOST_TIMEOUT_EN
   localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [TCW-1:0] tcnt;

   // Held at zero outside WAIT, so it restarts from zero on every entry to WAIT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 tcnt <= '0;
      else if (state != S_WAIT) tcnt <= '0;
      else                     tcnt <= tcnt + 1'b1;
   end

   // A done pulse in the expiry cycle takes priority over the timeout.
   assign tmo = (state == S_WAIT) && !mm_done_irq_p && (tcnt == TCW'(TIMEOUT - 1));
`else
   assign tmo = 1'b0;
`endif

   assign err_p = tmo;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_LOAD;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_LOAD:   if (in_fire && last_in) state_nxt = S_START;
         S_START:  state_nxt = S_WAIT;
         S_WAIT: begin
            if (mm_done_irq_p)  state_nxt = S_UNLOAD;
            else if (tmo)       state_nxt = S_LOAD;
         end
         S_UNLOAD: if (out_fire && last_out) state_nxt = S_LOAD;
         default:  state_nxt = S_LOAD;
      endcase
   end

   // wc is shared: it counts input words in LOAD and output words in UNLOAD.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wc  <= '0;
         a_q <= '0;
         b_q <= '0;
         m_q <= '0;
         y_q <= '0;
      end else begin
         if (in_fire) begin
            wc <= last_in ? '0 : wc + 1'b1;
            if (wc < WCW'(NBYP))          a_q <= {in_data, a_q[NBITS-1:PBITS]};
            else if (wc < WCW'(2 * NBYP)) b_q <= {in_data, b_q[NBITS-1:PBITS]};
            else                          m_q <= {in_data, m_q[NBITS-1:PBITS]};
         end
         if ((state == S_WAIT) && mm_done_irq_p) begin
            y_q <= mm_y;
         end else if (out_fire) begin
            y_q <= y_q >> PBITS;
            wc  <= last_out ? '0 : wc + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mod_mul_host_if.sv
// Bench for mod_mul_host_if: table vectors, random jobs vs arithmetic reference, and hand-written
// corner sequences (stray done pulses, reset during WAIT, WAIT timeout / hang).
`timescale 1ns/1ps
module tb_mod_mul_host_if;
   localparam int NBITS = 64;
   localparam int PBITS = 16;
   localparam int NBYP  = 4;
`ifdef MM_HOST_TIMEOUT_EN
   localparam int TMO = 100;
`else
   localparam int TMO = 8192;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [PBITS-1:0] in_data = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [PBITS-1:0] out_data;
   logic             busy, err_p, mm_enable_p;
   logic [NBITS-1:0] mm_a, mm_b, mm_m;
   logic [NBITS-1:0] mm_y = '0;
   logic             mm_done_irq_p;
   logic [1:0]       dbg_state;

   int total = 0;
   int bad   = 0;
   logic [PBITS-1:0] exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   mod_mul_host_if #(.NBITS(NBITS), .PBITS(PBITS), .NBYP(NBYP), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .err_p(err_p), .mm_enable_p(mm_enable_p),
      .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m), .mm_y(mm_y),
      .mm_done_irq_p(mm_done_irq_p), .dbg_state(dbg_state)
   );

   // ---------------- multiplier model (programmable latency) ----------------
   logic model_done  = 1'b0;
   logic manual_done = 1'b0;
   logic model_hang  = 1'b0;
   int   mult_lat    = 2;
   int   lat_cnt     = 0;
   int   en_cnt      = 0;
   logic [NBITS-1:0] cap_a, cap_b, cap_m;

   assign mm_done_irq_p = model_done | manual_done;

   function automatic logic [63:0] modmul(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] m);
      logic [127:0] p;
      p = {64'd0, a} * {64'd0, b};
      p = p % {64'd0, m};
      return p[63:0];
   endfunction

   // mm_y is only meaningful in the done cycle; afterwards it is scrambled.
   always @(posedge clk) begin
      model_done <= 1'b0;
      if (model_done) mm_y <= {$urandom, $urandom};
      if (lat_cnt > 0) begin
         lat_cnt <= lat_cnt - 1;
         if (lat_cnt == 1) begin
            model_done <= 1'b1;
            mm_y       <= modmul(cap_a, cap_b, cap_m);
         end
      end else if (mm_enable_p && !model_hang) begin
         lat_cnt <= mult_lat;
         cap_a   <= mm_a;
         cap_b   <= mm_b;
         cap_m   <= mm_m;
      end
   end

   always @(posedge clk) if (mm_enable_p) en_cnt <= en_cnt + 1;

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Returns at the negedge of the cycle right after the last m word was accepted.
   task automatic send_job(input logic [63:0] a, input logic [63:0] b, input logic [63:0] m,
                           input int gap_pct);
      logic [191:0] all;
      all = {m, b, a};
      for (int i = 0; i < 3 * NBYP; i++) begin
         int g;
         g = 0;
         while (($urandom_range(0, 99) < gap_pct) && (g < 4)) begin
            in_valid = 1'b0;
            in_data  = PBITS'($urandom);
            @(negedge clk);
            g++;
         end
         in_valid = 1'b1;
         in_data  = all[16*i +: 16];
         g = 0;
         while (!in_ready && (g < 50)) begin
            @(negedge clk);
            g++;
         end
         check($sformatf("in_ready_w%0d", i), in_ready, 1);
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic recv_result(input int mode);
      int g;
      logic [PBITS-1:0] w;
      out_ready = 1'b0;
      g = 0;
      while (!out_valid && (g < 300)) begin
         @(negedge clk);
         g++;
      end
      check("out_valid_first", out_valid, 1);
      check("busy_fall", busy, 0);
      for (int i = 0; i < NBYP; i++) begin
         logic acc;
         w   = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
         acc = 1'b0;
         g   = 0;
         while (!acc) begin
            case (mode)
               0:       out_ready = 1'b1;
               1:       out_ready = ~out_ready;
               default: out_ready = (g > 20) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
            check($sformatf("out_word%0d", i), out_data, w);
            check($sformatf("out_valid%0d", i), out_valid, 1);
            acc = out_ready;
            g++;
            @(negedge clk);
         end
      end
      out_ready = 1'b0;
      check("out_valid_end", out_valid, 0);
      check("in_ready_end", in_ready, 1);
   endtask

   task automatic push_exp(input logic [63:0] y);
      for (int i = 0; i < NBYP; i++) exp_q.push_back(y[16*i +: 16]);
   endtask

   task automatic check_start(input logic [63:0] a, input logic [63:0] b, input logic [63:0] m);
      check("enable_hi", mm_enable_p, 1);
      check("busy_start", busy, 1);
      check("in_ready_start", in_ready, 0);
      check("mm_a", mm_a, a);
      check("mm_b", mm_b, b);
      check("mm_m", mm_m, m);
   endtask

   task automatic run_job(input logic [63:0] a, input logic [63:0] b, input logic [63:0] m,
                          input logic [63:0] y, input int gap, input int mode, input int lat);
      int en0;
      mult_lat = lat;
      en0 = en_cnt;
      push_exp(y);
      send_job(a, b, m, gap);
      check_start(a, b, m);
      @(negedge clk);
      check("enable_lo", mm_enable_p, 0);
      check("busy_wait", busy, 1);
      recv_result(mode);
      check("enable_count", 64'(en_cnt - en0), 1);
   endtask

   typedef struct {
      logic [63:0] a, b, m, y;
      int          gap, mode, lat;
   } vec_t;

   vec_t vecs[3];

   initial begin
      logic [63:0] ra, rb, rm;

      vecs[0] = '{a: 64'd3, b: 64'd5, m: 64'd7, y: 64'd1, gap: 0, mode: 0, lat: 2};
      vecs[1] = '{a: 64'h0123_4567_89AB_CDEF, b: 64'd2, m: 64'hFFFF_FFFF_FFFF_FFC5,
                  y: 64'h0246_8ACF_1357_9BDE, gap: 40, mode: 1, lat: 5};
      vecs[2] = '{a: 64'hFFFF_FFFF_FFFF_FFC4, b: 64'hFFFF_FFFF_FFFF_FFC4,
                  m: 64'hFFFF_FFFF_FFFF_FFC5, y: 64'd1, gap: 20, mode: 2, lat: 1};

      // reset
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err_p, 0);
      check("rst_enable", mm_enable_p, 0);
      check("rst_mm_a", mm_a, 0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1);
      check("post_rst_out_valid", out_valid, 0);

      // table vectors
      for (int v = 0; v < 3; v++)
         run_job(vecs[v].a, vecs[v].b, vecs[v].m, vecs[v].y, vecs[v].gap, vecs[v].mode, vecs[v].lat);

      // random jobs against the arithmetic reference
      for (int j = 0; j < 6; j++) begin
         rm = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : {32'd0, $urandom};
         if (rm < 2) rm = 64'd2;
         ra = {$urandom, $urandom} % rm;
         rb = {$urandom, $urandom} % rm;
         run_job(ra, rb, rm, modmul(ra, rb, rm), $urandom_range(0, 50), $urandom_range(0, 2),
                 $urandom_range(1, 8));
      end

      // stray done pulses in idle LOAD, mid-LOAD and UNLOAD
      manual_done = 1'b1;
      @(negedge clk);
      manual_done = 1'b0;
      check("stray_idle_in_ready", in_ready, 1);
      check("stray_idle_busy", busy, 0);
      check("stray_idle_out_valid", out_valid, 0);
      ra = 64'h1111_2222_3333_4444;
      rb = 64'h0000_0000_0000_0003;
      rm = 64'h7FFF_FFFF_FFFF_FFE7;
      mult_lat = 3;
      push_exp(modmul(ra, rb, rm));
      fork
         send_job(ra, rb, rm, 0);
         begin
            repeat (5) @(negedge clk);
            manual_done = 1'b1;
            @(negedge clk);
            manual_done = 1'b0;
         end
      join
      check_start(ra, rb, rm);
      fork
         recv_result(0);
         begin
            for (int g = 0; (g < 300) && !out_valid; g++) @(negedge clk);
            @(negedge clk);
            manual_done = 1'b1;
            @(negedge clk);
            manual_done = 1'b0;
         end
      join

      // reset two cycles into WAIT, stale done arrives after release
      mult_lat = 10;
      send_job(64'h0BAD_F00D_1234_5678, 64'h55, 64'hFFFF_0000_FFFF_0001, 10);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("wrst_in_ready", in_ready, 0);
      check("wrst_out_valid", out_valid, 0);
      check("wrst_out_data", out_data, 0);
      check("wrst_busy", busy, 0);
      check("wrst_err", err_p, 0);
      check("wrst_enable", mm_enable_p, 0);
      check("wrst_mm_a", mm_a, 0);
      check("wrst_mm_m", mm_m, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("stale_in_ready", in_ready, 1);
         check("stale_out_valid", out_valid, 0);
      end
      run_job(64'd2, 64'd3, 64'd11, 64'd6, 0, 0, 2);

      // multiplier never answers
      model_hang = 1'b1;
      send_job(64'd4, 64'd5, 64'd13, 0);
      check_start(64'd4, 64'd5, 64'd13);
`ifdef MM_HOST_TIMEOUT_EN
      for (int i = 1; i <= 104; i++) begin
         @(negedge clk);
         check($sformatf("tmo_err_c%0d", i), err_p, (i == 100));
         check("tmo_out_valid", out_valid, 0);
         if (i == 101) begin
            check("tmo_in_ready", in_ready, 1);
            check("tmo_busy", busy, 0);
         end
      end
`else
      for (int i = 1; i <= 150; i++) begin
         @(negedge clk);
         check("hang_busy", busy, 1);
         check("hang_err", err_p, 0);
         check("hang_out_valid", out_valid, 0);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
`endif
      model_hang = 1'b0;
      run_job(64'd9, 64'd9, 64'd10, 64'd1, 10, 1, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mod_mul_host_if.md
# mod_mul_host_if

Word-serial host front end for the interleaved modular multiplier. It accepts the operands a, b and m as a stream of PBITS-wide words over a valid/ready input port. It then issues the multiplier's single-cycle start pulse and waits for the multiplier's done pulse. Finally it returns the NBITS result y as PBITS-wide words over a valid/ready output port. It is the initiator side of the multiplier's enable_p / done_irq_p handshake and sits between the bus fabric and the multiplier core.

## Interface
- NBITS, 4096, operand and result width.
- PBITS, 16, word width of the stream ports.
- NBYP, 256, words per operand; must equal NBITS/PBITS.
- TIMEOUT, 8192, WAIT-state cycle limit; used only when MM_HOST_TIMEOUT_EN is defined.

Ports (clock and reset first):
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid & in_ready.
- in_data  in  PBITS  operand word.
- out_valid  out  1  result word valid.
- out_ready  in  1  result word consumed when out_valid & out_ready.
- out_data  out  PBITS  result word.
- busy  out  1  high in START and WAIT.
- err_p  out  1  one-cycle timeout pulse; tied 0 without MM_HOST_TIMEOUT_EN.
- mm_enable_p  out  1  start pulse to the multiplier.
- mm_a, mm_b, mm_m  out  NBITS  operand registers driven to the multiplier.
- mm_y  in  NBITS  multiplier result.
- mm_done_irq_p  in  1  multiplier completion pulse.

## Operation
- The state machine has four states: LOAD, START, WAIT and UNLOAD. Reset state is LOAD.
- LOAD
  - in_ready = 1.
  - A word counter wc runs 0..3·NBYP−1 and advances only on an accepted word.
  - Words 0..NBYP−1 go to mm_a, NBYP..2NBYP−1 to mm_b, and 2NBYP..3NBYP−1 to mm_m, least-significant word first.
  - Each accepted word is shifted in from the top: reg <= {in_data, reg[NBITS-1:PBITS]}.
  - When the last m word is accepted, go to START and clear wc.
- START: lasts exactly one cycle with mm_enable_p = 1, then go to WAIT.
- WAIT
  - Hold mm_a, mm_b and mm_m stable.
  - On mm_done_irq_p, capture mm_y into the output shift register and go to UNLOAD.
- UNLOAD
  - out_valid = 1 and out_data = shift register [PBITS-1:0].
  - On each handshake, shift right by PBITS and increment wc.
  - When word NBYP−1 is accepted, return to LOAD with wc = 0.
- mm_done_irq_p is ignored in LOAD, START and UNLOAD.
- mm_a, mm_b and mm_m are not cleared between jobs; every job fully overwrites them.
- There are no arithmetic checks: operands are forwarded unmodified, and the caller guarantees a, b < m.

## Timing
- Reset values: state LOAD, wc 0, all operand and result registers 0.
- Output reset values: mm_enable_p 0, out_valid 0, out_data 0, busy 0, err_p 0. in_ready is forced to 0 while rst is high and is 1 in the first cycle after release.
- Last m word accepted at edge k:
  - mm_enable_p is high in cycle k+1;
  - busy is high from cycle k+1.
- mm_done_irq_p seen at edge d: out_valid and the first result word appear in cycle d+1, and busy falls in the same cycle.
- Input and output stalls of any length are allowed. Data and valid hold while the partner is not ready.
- in_ready = 0 outside LOAD, so there is no overlap between jobs.
- Reset asserted mid-operation aborts the job immediately. A done pulse still arriving after reset release is ignored, because the block is then in LOAD.
- Throughput: one word per cycle on each port; 3·NBYP + NBYP + multiplier latency + 2 cycles per job.

## Configuration
- MM_HOST_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT−1 without a done pulse, err_p pulses for one cycle, the state returns to LOAD, and no result is emitted.
  - A done pulse and the timeout in the same cycle: the done pulse wins.
- MM_HOST_TIMEOUT_EN undefined: no counter; err_p = 0; WAIT is held until done.

## Test plan
Bench parameters are NBITS=64, PBITS=16, NBYP=4. The multiplier is modelled with programmable latency.
- a=3, b=5, m=7 streamed without gaps → mm_enable_p pulses once, then out words 0x0001, 0x0000, 0x0000, 0x0000.
- a=0x0123_4567_89AB_CDEF, b=2, m=0xFFFF_FFFF_FFFF_FFC5 with random in_valid gaps and out_ready toggling every cycle → out words are the LSW-first split of a·b mod m; each word holds while out_ready is low.
- mm_done_irq_p pulsed during LOAD and during UNLOAD → no state change; output words are unchanged.
- rst asserted two cycles into WAIT, then a new job a=2, b=3, m=11 → all outputs 0 during reset; a stale done pulse is ignored; result is 0x0006.
- With MM_HOST_TIMEOUT_EN and TIMEOUT=100, the model never returns done → err_p pulses in the 100th WAIT cycle, then in_ready = 1 and out_valid is never asserted. Without the macro, busy stays 1.
